// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: operand source encodings and register index width.
package ex_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] SRC_RS   = 2'b00;
    localparam logic [1:0] SRC_PC   = 2'b01;
    localparam logic [1:0] SRC_ZERO = 2'b10;
    localparam logic [1:0] SRC_IMM  = 2'b11;

endpackage

// File: rtl/ex_fwd_pick.sv
// Forwarding resolution for one register source: lowest matching index wins, x0 never forwards.
module ex_fwd_pick
    import ex_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                          en,
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic [XLEN-1:0]               rs_data,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]       fwd_data,
    output logic                          hit,
    output logic                          pending,
    output logic [XLEN-1:0]               data
);

    // Scan upward and latch the first match so younger stages take priority.
    always_comb begin
        hit     = 1'b0;
        pending = 1'b0;
        data    = rs_data;
        for (int i = 0; i < int'(NUM_FWD); i++) begin
            if (!hit && en && fwd_valid[i] && (rs_addr != '0)
                && (fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
                hit     = 1'b1;
                pending = fwd_pending[i];
                data    = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Registered EX operand-1 select with forwarding, load-use stall, valid/ready handshake and stall counter.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    src_sel,
    input  logic [REG_ADDR_W-1:0]         rs_addr,
    input  logic [XLEN-1:0]               rs_data,
    input  logic [XLEN-1:0]               pc,
    input  logic [XLEN-1:0]               imm,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]       fwd_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               operand,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic            fwd_hit;
    logic            fwd_pend;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] sel_val;
    logic            hazard;
    logic            accept;

    ex_fwd_pick #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_pick (
        .en          (src_sel == SRC_RS),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .hit         (fwd_hit),
        .pending     (fwd_pend),
        .data        (rs_val)
    );

    assign hazard    = fwd_hit && fwd_pend;
    assign out_valid = (state == ST_FULL);
    assign in_ready  = !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        sel_val = '0;
        case (src_sel)
            SRC_RS:   sel_val = rs_val;
            SRC_PC:   sel_val = pc;
            SRC_ZERO: sel_val = '0;
            SRC_IMM:  sel_val = imm;
            default:  sel_val = '0;
        endcase
    end

    // Flush dominates; otherwise accept refills, a bare consume empties.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (accept) begin
            state_nxt = ST_FULL;
        end else if (out_valid && out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operand <= '0;
        end else if (accept) begin
            operand <= sel_val;
        end
    end

    // Counts hazard cycles even while flushing; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for operand selection plus handshake/stall sequences.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sat_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  src_sel;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_pending;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_operand;
    logic [1:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_operand_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .rs_addr(rs_addr), .rs_data(rs_data), .pc(pc), .imm(imm),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .operand(operand), .stall_cnt(stall_cnt)
    );

    ex_operand_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(sat_rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .src_sel(src_sel), .rs_addr(rs_addr), .rs_data(rs_data), .pc(pc), .imm(imm),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .operand(s_operand), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rs_addr;
        logic [31:0] rs_data;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [1:0]  fv;
        logic [1:0]  fp;
        logic [9:0]  rd;
        logic [63:0] fd;
        logic [31:0] exp_op;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        src_sel     = 2'b00;
        rs_addr     = 5'd0;
        rs_data     = 32'h0;
        pc          = 32'h0;
        imm         = 32'h0;
        fwd_valid   = 2'b00;
        fwd_pending = 2'b00;
        fwd_rd      = 10'd0;
        fwd_data    = 64'h0;
        flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b01, 5'd0, 32'h0,  32'h1000, 32'h0,        2'b00, 2'b00, {5'd0, 5'd0}, {32'hBB, 32'hAA}, 32'h1000};
        vecs[1] = '{2'b00, 5'd3, 32'h33, 32'h0,    32'h0,        2'b00, 2'b00, {5'd0, 5'd0}, {32'hBB, 32'hAA}, 32'h33};
        vecs[2] = '{2'b00, 5'd5, 32'h11, 32'h0,    32'h0,        2'b11, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'hAA};
        vecs[3] = '{2'b00, 5'd5, 32'h11, 32'h0,    32'h0,        2'b11, 2'b00, {5'd5, 5'd6}, {32'hBB, 32'hAA}, 32'hBB};
        vecs[4] = '{2'b00, 5'd0, 32'h77, 32'h0,    32'h0,        2'b01, 2'b00, {5'd0, 5'd0}, {32'hBB, 32'hAA}, 32'h77};
        vecs[5] = '{2'b10, 5'd5, 32'h11, 32'h1234, 32'h5678,     2'b11, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'h0};
        vecs[6] = '{2'b11, 5'd5, 32'h11, 32'h0,    32'hDEADBEEF, 2'b01, 2'b01, {5'd6, 5'd5}, {32'hBB, 32'hAA}, 32'hDEADBEEF};
        vecs[7] = '{2'b00, 5'd9, 32'h11, 32'h0,    32'h0,        2'b10, 2'b00, {5'd9, 5'd9}, {32'hBB, 32'hAA}, 32'hBB};
        vecs[8] = '{2'b00, 5'd5, 32'h11, 32'h0,    32'h0,        2'b11, 2'b10, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'hAA};
        vecs[9] = '{2'b00, 5'd4, 32'h44, 32'h0,    32'h0,        2'b00, 2'b11, {5'd4, 5'd4}, {32'hBB, 32'hAA}, 32'h44};

        // Reset held with a live request.
        idle_inputs();
        rst_n     = 1'b0;
        sat_rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        src_sel   = 2'b01;
        pc        = 32'h0000_1000;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_operand", 64'(operand), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_operand", 64'(operand), 64'h1000);
        check("post_rst_out_valid", 64'(out_valid), 64'd1);

        // Operand selection table at full throughput.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            src_sel     = vecs[i].src;
            rs_addr     = vecs[i].rs_addr;
            rs_data     = vecs[i].rs_data;
            pc          = vecs[i].pc;
            imm         = vecs[i].imm;
            fwd_valid   = vecs[i].fv;
            fwd_pending = vecs[i].fp;
            fwd_rd      = vecs[i].rd;
            fwd_data    = vecs[i].fd;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
            step();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_operand", i), 64'(operand), 64'(vecs[i].exp_op));
        end
        check("table_stall_cnt", 64'(stall_cnt), 64'd0);

        // Drain with no new request.
        @(negedge clk);
        idle_inputs();
        step();
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_operand_hold", 64'(operand), 64'h44);

        // Load-use stall on source 0, then resolve in the same cycle.
        @(negedge clk);
        in_valid    = 1'b1;
        src_sel     = 2'b00;
        rs_addr     = 5'd7;
        rs_data     = 32'h99;
        fwd_valid   = 2'b01;
        fwd_pending = 2'b01;
        fwd_rd      = {5'd0, 5'd7};
        fwd_data    = {32'h0, 32'h0};
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            step();
            @(negedge clk);
        end
        check("stall_cnt_3", 64'(stall_cnt), 64'd3);
        check("stall_out_valid", 64'(out_valid), 64'd0);
        fwd_pending = 2'b00;
        fwd_data    = {32'h0, 32'h1234};
        #1;
        check("resolve_in_ready", 64'(in_ready), 64'd1);
        step();
        check("resolve_operand", 64'(operand), 64'h1234);
        check("resolve_out_valid", 64'(out_valid), 64'd1);
        check("resolve_stall_cnt", 64'(stall_cnt), 64'd3);

        // Backpressure holds the current operand.
        @(negedge clk);
        idle_inputs();
        in_valid = 1'b1;
        src_sel  = 2'b11;
        imm      = 32'h55;
        step();
        check("bp_load_55", 64'(operand), 64'h55);
        @(negedge clk);
        out_ready = 1'b0;
        imm       = 32'h66;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        step();
        check("bp_hold_operand", 64'(operand), 64'h55);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_load_66", 64'(operand), 64'h66);

        // Flush while FULL with a valid request; in_ready ignores flush.
        @(negedge clk);
        imm   = 32'h99;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_operand", 64'(operand), 64'h66);

        // Flush during a hazard still counts the stall cycle.
        @(negedge clk);
        src_sel     = 2'b00;
        rs_addr     = 5'd7;
        fwd_valid   = 2'b01;
        fwd_pending = 2'b01;
        fwd_rd      = {5'd0, 5'd7};
        step();
        check("flush_hazard_cnt", 64'(stall_cnt), 64'd4);
        check("flush_hazard_valid", 64'(out_valid), 64'd0);

        // Saturation on the 2-bit counter instance.
        @(negedge clk);
        flush     = 1'b0;
        sat_rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("sat_cnt_%0d", c), 64'(s_stall_cnt), (c < 3) ? 64'(c) : 64'd3);
        end
        check("sat_no_accept", 64'(s_out_valid), 64'd0);

        @(negedge clk);
        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Parametrised, registered successor to the EX-stage ALU operand-1 select. Chooses an operand from register-file data, PC, zero or immediate, resolves forwarding from `NUM_FWD` later pipeline stages, and holds the result in an output register with a valid/ready handshake. It stalls on a pending (not-yet-available) forward, supports flush, and counts stall cycles. It sits between the ID/EX register and the ALU input.

## Interface
- `XLEN`, default 32: operand and data width.
- `NUM_FWD`, default 2: number of forwarding sources; index 0 is the youngest (EX/MEM) and has the highest priority.
- `CNT_W`, default 16: width of the stall counter.

Ports (synchronous, active-low reset):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `in_valid`  in  1: upstream operand request valid.
- `in_ready`  out  1: stage can accept the request this cycle.
- `src_sel`  in  2: source select. 00 = rs, 01 = pc, 10 = zero, 11 = imm.
- `rs_addr`  in  5: source register index.
- `rs_data`  in  XLEN: register-file read data.
- `pc`  in  XLEN: ID/EX PC.
- `imm`  in  XLEN: decoded immediate.
- `fwd_valid`  in  NUM_FWD: source i holds a register write.
- `fwd_pending`  in  NUM_FWD: source i's data is not yet available (load in flight).
- `fwd_rd`  in  5*NUM_FWD: destination register of source i, packed.
- `fwd_data`  in  XLEN*NUM_FWD: write data of source i, packed.
- `flush`  in  1: discard the held operand and any request this cycle.
- `out_valid`  out  1: `operand` is valid.
- `out_ready`  in  1: ALU consumes the operand.
- `operand`  out  XLEN: registered operand.
- `stall_cnt`  out  CNT_W: saturating count of hazard-stall cycles.

## Operation
- **Forward match.** Source i matches when `fwd_valid[i]`, `fwd_rd[i]==rs_addr`, `rs_addr!=0` and `src_sel==00`.
  - The lowest matching index wins.
  - With no match, the rs value is `rs_data`.
- **Hazard.** A hazard exists when the winning match has `fwd_pending` set. A pending bit on a non-winning source is ignored.
- **Selection.** 00 gives the rs value (forwarded or register-file). 01 gives `pc`. 10 gives 0. 11 gives `imm`. All selections are defined; there is no latch.
- **Ready.** `in_ready = !hazard && (!out_valid || out_ready)`.
- **Accept.** A request is accepted when `in_valid && in_ready && !flush`. On accept, `operand` loads the selected value and `out_valid` is set to 1.
- **Drain.** If `out_valid && out_ready` and nothing is accepted in the same cycle, `out_valid` clears. `operand` holds its last value.
- **Flush.** `flush` has priority over accept and drain: next cycle `out_valid`=0 and nothing is accepted. `stall_cnt` still counts that cycle if it is a hazard cycle.
- **Stall counter.** `stall_cnt` increments on every cycle with `in_valid && hazard` and saturates at all-ones without wrapping.
- **States.** Two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY to FULL on accept.
  - FULL to FULL on consume-and-accept, or when held (`!out_ready`).
  - FULL to EMPTY on consume without accept, or on flush.
  - Any state to EMPTY on flush or reset.

## Timing
- **Reset.** Reset has priority over everything, including mid-handshake. Reset values: `out_valid`=0, `operand`=0, `stall_cnt`=0.
- **Combinational outputs.** `in_ready` is combinational from `out_valid`, `out_ready` and the hazard inputs. It is not affected by `flush`.
- **Latency.** One cycle from accept to `out_valid`.
- **Throughput.** One operand per cycle when `out_ready` is held high and no hazard is present.
- **Hazard resolution.** When the pending source drops `fwd_pending`, the request is accepted in that same cycle with the now-valid `fwd_data`.
- **Held request.** Upstream must keep `in_valid` and the request fields stable while `in_ready`=0.

## Structure
- **Shared package `ex_pkg`.** Holds the `src_sel` encodings (`SRC_RS`, `SRC_PC`, `SRC_ZERO`, `SRC_IMM`) and `REG_ADDR_W`=5. Later EX-stage muxes import the same package.
- **Sub-module `ex_fwd_pick`.** Purely combinational, parametrised on `XLEN`/`NUM_FWD`. Outputs `hit`, `pending` and `data`. The top level holds the handshake, registers and counter.

## Test plan
- **Reset.** Drive `rst_n`=0 for 2 cycles with `in_valid`=1 -> `out_valid`=0, `operand`=0, `stall_cnt`=0. Release reset, then `src_sel`=01, `pc`=0x0000_1000 -> next cycle `operand`=0x0000_1000, `out_valid`=1.
- **Priority forward and x0.**
  - `rs_addr`=5, `rs_data`=0x11; source 0 rd=5 data=0xAA; source 1 rd=5 data=0xBB -> `operand`=0xAA.
  - `rs_addr`=0 with source 0 rd=0 data=0xAA -> `operand` = `rs_data`.
- **Load-use stall.** Source 0 rd=7 pending for 3 cycles, `rs_addr`=7 -> `in_ready`=0 for 3 cycles and `stall_cnt`=3. Pending drops with data=0x1234 -> accepted that cycle, `operand`=0x1234.
- **Backpressure.** `out_ready`=0 with FULL and `operand`=0x55, new request imm=0x66 -> `operand` stays 0x55 and `in_ready`=0. Raise `out_ready` -> 0x66 is loaded next cycle.
- **Flush.** FULL plus a valid request, assert `flush` -> next cycle `out_valid`=0 and the request is not loaded.
- **Counter saturation.** `CNT_W`=2, 5 hazard cycles -> `stall_cnt`=3.
